// File: rtl/mem_port_arbiter.sv
// Shared instruction/data memory port sequencer for the multicycle MIPS datapath.
// Round-robin arbitration between fetch and load/store, fixed read latency, misalignment errors.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              If_req,
  input  logic [ADDR_W-1:0] If_addr,
  output logic              If_ack,
  input  logic              D_req,
  input  logic              D_wr,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic              D_ack,
  output logic [DATA_W-1:0] Rdata,
  output logic              Err,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [DATA_W-1:0] Mem_wdata,
  output logic              Mem_wr,
  input  logic [DATA_W-1:0] Mem_rdata,
  output logic              Busy,
  output logic              Grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT = 4'(READ_LAT);

  state_t            state;
  logic              last_grant;
  logic [3:0]        wait_cnt;
  logic              pick_d;
  logic [ADDR_W-1:0] win_addr;
  logic              misaligned;

  // On a conflict the requester that did not win last time gets the port.
  always_comb begin
    pick_d = D_req;
    if (If_req && D_req)
      pick_d = ~last_grant;
    win_addr   = pick_d ? D_addr : If_addr;
    misaligned = (win_addr[1:0] != 2'b00);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wait_cnt   <= 4'd0;
      Mem_addr   <= '0;
      Mem_wdata  <= '0;
      Mem_wr     <= 1'b0;
      If_ack     <= 1'b0;
      D_ack      <= 1'b0;
      Rdata      <= '0;
      Err        <= 1'b0;
      Busy       <= 1'b0;
      Grant      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (If_req || D_req) begin
            Grant      <= pick_d;
            last_grant <= pick_d;
            Mem_addr   <= win_addr;
            Mem_wdata  <= pick_d ? D_wdata : '0;
            Busy       <= 1'b1;
            // Misaligned words skip the memory entirely and report at once.
            if (misaligned) begin
              state  <= DONE;
              Err    <= 1'b1;
              Rdata  <= '0;
              If_ack <= ~pick_d;
              D_ack  <= pick_d;
            end else begin
              state  <= ISSUE;
              Mem_wr <= pick_d & D_wr;
            end
          end
        end
        ISSUE: begin
          if (Mem_wr) begin
            Mem_wr <= 1'b0;
            Rdata  <= '0;
            If_ack <= ~Grant;
            D_ack  <= Grant;
            state  <= DONE;
          end else begin
            wait_cnt <= 4'd1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == LAT) begin
            Rdata    <= Mem_rdata;
            If_ack   <= ~Grant;
            D_ack    <= Grant;
            wait_cnt <= 4'd0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          If_ack <= 1'b0;
          D_ack  <= 1'b0;
          Err    <= 1'b0;
          Rdata  <= '0;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, store, round-robin, misalignment,
// mid-read reset and read-latency sweep on extra instances with READ_LAT 1 and 5.
module tb_mem_port_arbiter;

  logic        Clk, Reset_n;
  logic        If_req, D_req, D_wr;
  logic [31:0] If_addr, D_addr, D_wdata, Mem_rdata;
  logic        If_ack, D_ack, Err, Mem_wr, Busy, Grant;
  logic [31:0] Rdata, Mem_addr, Mem_wdata;

  logic        if_req1, if_ack1, d_ack1, err1, mem_wr1, busy1, grant1;
  logic [31:0] rdata1, mem_addr1, mem_wdata1;
  logic        if_req5, if_ack5, d_ack5, err5, mem_wr5, busy5, grant5;
  logic [31:0] rdata5, mem_addr5, mem_wdata5;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .If_req(If_req), .If_addr(If_addr), .If_ack(If_ack),
    .D_req(D_req), .D_wr(D_wr), .D_addr(D_addr), .D_wdata(D_wdata), .D_ack(D_ack),
    .Rdata(Rdata), .Err(Err), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
    .Mem_wr(Mem_wr), .Mem_rdata(Mem_rdata), .Busy(Busy), .Grant(Grant)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1)) dut_l1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .If_req(if_req1), .If_addr(If_addr), .If_ack(if_ack1),
    .D_req(1'b0), .D_wr(1'b0), .D_addr(32'h0), .D_wdata(32'h0), .D_ack(d_ack1),
    .Rdata(rdata1), .Err(err1), .Mem_addr(mem_addr1), .Mem_wdata(mem_wdata1),
    .Mem_wr(mem_wr1), .Mem_rdata(Mem_rdata), .Busy(busy1), .Grant(grant1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(5)) dut_l5 (
    .Clk(Clk), .Reset_n(Reset_n),
    .If_req(if_req5), .If_addr(If_addr), .If_ack(if_ack5),
    .D_req(1'b0), .D_wr(1'b0), .D_addr(32'h0), .D_wdata(32'h0), .D_ack(d_ack5),
    .Rdata(rdata5), .Err(err5), .Mem_addr(mem_addr5), .Mem_wdata(mem_wdata5),
    .Mem_wr(mem_wr5), .Mem_rdata(Mem_rdata), .Busy(busy5), .Grant(grant5)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    tick();
    tick();
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (Mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_wr: got %b expected 0", Mem_wr); end
    checks++; if (Mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", Mem_addr); end
    checks++; if (Mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0", Mem_wdata); end
    checks++; if ({If_ack, D_ack, Err, Grant} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {If_ack, D_ack, Err, Grant}); end
    checks++; if (Rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", Rdata); end
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    If_addr   = 32'h0000_0040;
    Mem_rdata = 32'hBAD0_0000;
    If_req    = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) Mem_rdata = 32'h8C01_0004;
      checks++; if (If_ack !== (c == 4)) begin errors++; $display("[TB] FAIL fetch_if_ack c%0d: got %b expected %b", c, If_ack, (c == 4)); end
      checks++; if (D_ack !== 1'b0) begin errors++; $display("[TB] FAIL fetch_d_ack c%0d: got %b expected 0", c, D_ack); end
      if (c == 1) begin
        checks++; if (Mem_addr !== 32'h40) begin errors++; $display("[TB] FAIL fetch_mem_addr: got %h expected 40", Mem_addr); end
        checks++; if ({Busy, Grant, Mem_wr} !== 3'b100) begin errors++; $display("[TB] FAIL fetch_busy_grant_wr: got %b expected 100", {Busy, Grant, Mem_wr}); end
      end
      if (c == 4) begin
        checks++; if (Rdata !== 32'h8C01_0004) begin errors++; $display("[TB] FAIL fetch_rdata: got %h expected 8c010004", Rdata); end
        checks++; if (Err !== 1'b0) begin errors++; $display("[TB] FAIL fetch_err: got %b expected 0", Err); end
        If_req = 1'b0;
      end
      if (c == 5) begin
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL fetch_idle_busy: got %b expected 0", Busy); end
      end
    end
  endtask

  task automatic test_store();
    D_wr    = 1'b1;
    D_addr  = 32'h0000_0100;
    D_wdata = 32'hDEAD_BEEF;
    D_req   = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (Mem_wr !== (c == 1)) begin errors++; $display("[TB] FAIL store_mem_wr c%0d: got %b expected %b", c, Mem_wr, (c == 1)); end
      checks++; if (D_ack !== (c == 2)) begin errors++; $display("[TB] FAIL store_d_ack c%0d: got %b expected %b", c, D_ack, (c == 2)); end
      checks++; if (If_ack !== 1'b0) begin errors++; $display("[TB] FAIL store_if_ack c%0d: got %b expected 0", c, If_ack); end
      if (c == 1) begin
        checks++; if (Mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL store_mem_addr: got %h expected 100", Mem_addr); end
        checks++; if (Mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL store_mem_wdata: got %h expected deadbeef", Mem_wdata); end
      end
      if (c == 2) begin
        checks++; if (Rdata !== 32'h0) begin errors++; $display("[TB] FAIL store_rdata: got %h expected 0", Rdata); end
        checks++; if (Mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL store_addr_hold: got %h expected 100", Mem_addr); end
        D_req = 1'b0;
      end
      if (c == 3) begin
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL store_idle_busy: got %b expected 0", Busy); end
      end
    end
  endtask

  // Both requests held: fetch (ack c4), data load (ack c9), fetch again (ack c14).
  task automatic test_round_robin();
    If_addr   = 32'h0000_0044;
    D_addr    = 32'h0000_0200;
    D_wr      = 1'b0;
    Mem_rdata = 32'h1111_0001;
    If_req    = 1'b1;
    D_req     = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 5)  Mem_rdata = 32'h2222_0002;
      if (c == 10) Mem_rdata = 32'h3333_0003;
      checks++; if (If_ack !== (c == 4 || c == 14)) begin errors++; $display("[TB] FAIL rr_if_ack c%0d: got %b expected %b", c, If_ack, (c == 4 || c == 14)); end
      checks++; if (D_ack !== (c == 9)) begin errors++; $display("[TB] FAIL rr_d_ack c%0d: got %b expected %b", c, D_ack, (c == 9)); end
      if (c == 1 || c == 11) begin
        checks++; if (Grant !== 1'b0) begin errors++; $display("[TB] FAIL rr_grant_fetch c%0d: got %b expected 0", c, Grant); end
      end
      if (c == 6) begin
        checks++; if (Grant !== 1'b1) begin errors++; $display("[TB] FAIL rr_grant_data: got %b expected 1", Grant); end
        checks++; if (Mem_addr !== 32'h200) begin errors++; $display("[TB] FAIL rr_data_addr: got %h expected 200", Mem_addr); end
      end
      if (c == 4) begin
        checks++; if (Rdata !== 32'h1111_0001) begin errors++; $display("[TB] FAIL rr_rdata1: got %h expected 11110001", Rdata); end
      end
      if (c == 9) begin
        checks++; if (Rdata !== 32'h2222_0002) begin errors++; $display("[TB] FAIL rr_rdata2: got %h expected 22220002", Rdata); end
      end
      if (c == 14) begin
        checks++; if (Rdata !== 32'h3333_0003) begin errors++; $display("[TB] FAIL rr_rdata3: got %h expected 33330003", Rdata); end
        If_req = 1'b0;
        D_req  = 1'b0;
      end
    end
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle_busy: got %b expected 0", Busy); end
  endtask

  task automatic test_misaligned();
    D_wr   = 1'b0;
    D_addr = 32'h0000_0102;
    D_req  = 1'b1;
    tick();
    checks++; if ({D_ack, If_ack, Err, Busy, Mem_wr} !== 5'b10110) begin errors++; $display("[TB] FAIL mis_ack_err: got %b expected 10110", {D_ack, If_ack, Err, Busy, Mem_wr}); end
    checks++; if (Rdata !== 32'h0) begin errors++; $display("[TB] FAIL mis_rdata: got %h expected 0", Rdata); end
    D_req = 1'b0;
    tick();
    checks++; if ({D_ack, Err, Busy, Mem_wr} !== 4'b0000) begin errors++; $display("[TB] FAIL mis_after: got %b expected 0000", {D_ack, Err, Busy, Mem_wr}); end
    If_addr   = 32'h0000_0048;
    Mem_rdata = 32'hBAD0_0000;
    If_req    = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) Mem_rdata = 32'h0123_4567;
      checks++; if (If_ack !== (c == 4)) begin errors++; $display("[TB] FAIL mis_fetch_ack c%0d: got %b expected %b", c, If_ack, (c == 4)); end
      if (c == 4) begin
        checks++; if ({Rdata, Err} !== {32'h0123_4567, 1'b0}) begin errors++; $display("[TB] FAIL mis_fetch_data: got %h/%b expected 01234567/0", Rdata, Err); end
        If_req = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    If_addr = 32'h0000_004C;
    If_req  = 1'b1;
    tick();
    tick();
    Reset_n = 1'b0;
    If_req  = 1'b0;
    tick();
    checks++; if ({Busy, If_ack, D_ack, Mem_wr, Grant} !== 5'b00000) begin errors++; $display("[TB] FAIL midreset_flags: got %b expected 00000", {Busy, If_ack, D_ack, Mem_wr, Grant}); end
    checks++; if (Mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL midreset_addr: got %h expected 0", Mem_addr); end
    Reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if ({If_ack, Busy} !== 2'b00) begin errors++; $display("[TB] FAIL midreset_no_ack c%0d: got %b expected 00", c, {If_ack, Busy}); end
    end
    If_addr   = 32'h0000_0050;
    D_addr    = 32'h0000_0204;
    D_wr      = 1'b0;
    Mem_rdata = 32'h5555_AAAA;
    If_req    = 1'b1;
    D_req     = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++; if (If_ack !== (c == 4)) begin errors++; $display("[TB] FAIL postreset_if_ack c%0d: got %b expected %b", c, If_ack, (c == 4)); end
      checks++; if (D_ack !== (c == 9)) begin errors++; $display("[TB] FAIL postreset_d_ack c%0d: got %b expected %b", c, D_ack, (c == 9)); end
      if (c == 1) begin
        checks++; if (Grant !== 1'b0) begin errors++; $display("[TB] FAIL postreset_grant: got %b expected 0", Grant); end
      end
      if (c == 4) If_req = 1'b0;
      if (c == 9) D_req = 1'b0;
    end
  endtask

  task automatic test_sweep(input int lat);
    logic ack_obs;
    logic [31:0] rd_obs;
    If_addr   = 32'h0000_0060;
    Mem_rdata = 32'hBAD0_0000;
    if (lat == 1) if_req1 = 1'b1; else if_req5 = 1'b1;
    for (int c = 1; c <= lat + 3; c++) begin
      tick();
      if (c == 2) Mem_rdata = 32'hC0DE_0000 + 32'(lat);
      ack_obs = (lat == 1) ? if_ack1 : if_ack5;
      rd_obs  = (lat == 1) ? rdata1 : rdata5;
      checks++; if (ack_obs !== (c == lat + 2)) begin errors++; $display("[TB] FAIL sweep%0d_ack c%0d: got %b expected %b", lat, c, ack_obs, (c == lat + 2)); end
      if (c == lat + 2) begin
        checks++; if (rd_obs !== 32'hC0DE_0000 + 32'(lat)) begin errors++; $display("[TB] FAIL sweep%0d_rdata: got %h expected %h", lat, rd_obs, 32'hC0DE_0000 + 32'(lat)); end
        if_req1 = 1'b0;
        if_req5 = 1'b0;
      end
    end
  endtask

  initial begin
    Reset_n   = 1'b0;
    If_req    = 1'b0;
    D_req     = 1'b0;
    D_wr      = 1'b0;
    If_addr   = 32'h0;
    D_addr    = 32'h0;
    D_wdata   = 32'h0;
    Mem_rdata = 32'h0;
    if_req1   = 1'b0;
    if_req5   = 1'b0;
    $display("[TB] starting mem_port_arbiter bench");
    test_reset();
    test_fetch();
    test_store();
    test_round_robin();
    test_misaligned();
    test_reset_mid();
    test_sweep(1);
    test_sweep(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
